// File: rtl/palette_pkg.sv
// Shared widths, RGB 4:4:4 layout and index helpers for the palette reader.
// The index-offset helper is only used when PALETTE_READER_OFFSET_EN is defined.
package palette_pkg;

    localparam int PAL_IDX_W  = 8;
    localparam int PAL_DATA_W = 16;
    localparam int RGB_W      = 12;

    localparam int R_MSB = 11;
    localparam int R_LSB = 8;
    localparam int G_MSB = 7;
    localparam int G_LSB = 4;
    localparam int B_MSB = 3;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    function automatic rgb444_t to_rgb(input logic [RGB_W-1:0] d);
        rgb444_t c;
        c.r = d[R_MSB:R_LSB];
        c.g = d[G_MSB:G_LSB];
        c.b = d[B_MSB:B_LSB];
        return c;
    endfunction

    // Index 0 is the transparent/background entry and is never relocated.
    function automatic logic [PAL_IDX_W-1:0] offset_idx(input logic [PAL_IDX_W-1:0] idx,
                                                        input logic [3:0] off);
        logic [3:0] hi;
        hi = idx[7:4] + off;
        return (idx == '0) ? idx : {hi, idx[3:0]};
    endfunction

endpackage

// File: rtl/palette_reader_fifo.sv
// Synchronous RGB FIFO with occupancy count; head is read straight from the
// storage flops so the output stage sees registered data. Any depth >= 2.
module palette_reader_fifo
    import palette_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  rgb444_t          push_data_i,
    input  logic             pop_i,
    output rgb444_t          head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rgb444_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/palette_reader.sv
// Streams 8-bit colour indices through the palette RAM to 12-bit RGB output.
// Define PALETTE_READER_OFFSET_EN to add pal_offset_i palette-bank relocation.
module palette_reader
    import palette_pkg::*;
#(
    parameter int FIFO_DEPTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pix_valid_i,
    output logic                  pix_ready_o,
    input  logic [PAL_IDX_W-1:0]  pix_idx_i,
    input  logic                  pix_blank_i,
`ifdef PALETTE_READER_OFFSET_EN
    input  logic [3:0]            pal_offset_i,
`endif
    output logic                  rgb_valid_o,
    input  logic                  rgb_ready_i,
    output logic [RGB_W-1:0]      rgb_o,
    output logic                  pal_rd_en_o,
    output logic [PAL_IDX_W-1:0]  pal_rd_addr_o,
    input  logic [PAL_DATA_W-1:0] pal_rd_data_i
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             s1_valid_q, s1_valid_d;
    logic             s1_blank_q, s1_blank_d;
    logic             accept, push, pop;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credits_used;
    rgb444_t          push_data, head;
    logic             unused_hi;

    // Credits count the pixel already in the RAM read stage so its data
    // always has a FIFO slot when it returns; no path from rgb_ready_i.
    assign credits_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid_q};
    assign pix_ready_o  = ~rst_i & (credits_used < (CNT_W + 1)'(FIFO_DEPTH));
    assign accept       = pix_valid_i & pix_ready_o;

`ifdef PALETTE_READER_OFFSET_EN
    assign pal_rd_addr_o = offset_idx(pix_idx_i, pal_offset_i);
`else
    assign pal_rd_addr_o = pix_idx_i;
`endif
    assign pal_rd_en_o = accept & ~pix_blank_i;

    always_comb begin
        s1_valid_d = accept;
        s1_blank_d = pix_blank_i;
        push       = s1_valid_q;
        push_data  = s1_blank_q ? '0 : to_rgb(pal_rd_data_i[RGB_W-1:0]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_blank_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_blank_q <= s1_blank_d;
        end
    end

    assign unused_hi = ^pal_rd_data_i[PAL_DATA_W-1:RGB_W];

    palette_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    assign rgb_valid_o = (fifo_count != '0);
    assign pop         = rgb_valid_o & rgb_ready_i;
    assign rgb_o       = head;

endmodule

// File: tb/tb_palette_reader.sv
// Scoreboard bench for palette_reader: random + directed stimulus, expected
// RGB pushed at accept time and compared by an independent output monitor.
module tb_palette_reader;

    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        pix_valid_i;
    logic        pix_ready_o;
    logic [7:0]  pix_idx_i;
    logic        pix_blank_i;
`ifdef PALETTE_READER_OFFSET_EN
    logic [3:0]  pal_offset_i;
`endif
    logic        rgb_valid_o;
    logic        rgb_ready_i;
    logic [11:0] rgb_o;
    logic        pal_rd_en_o;
    logic [7:0]  pal_rd_addr_o;
    logic [15:0] pal_rd_data_i;

    logic [15:0] mem [256];
    logic [11:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;

    always #5 clk = ~clk;

    palette_reader #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .pix_valid_i   (pix_valid_i),
        .pix_ready_o   (pix_ready_o),
        .pix_idx_i     (pix_idx_i),
        .pix_blank_i   (pix_blank_i),
`ifdef PALETTE_READER_OFFSET_EN
        .pal_offset_i  (pal_offset_i),
`endif
        .rgb_valid_o   (rgb_valid_o),
        .rgb_ready_i   (rgb_ready_i),
        .rgb_o         (rgb_o),
        .pal_rd_en_o   (pal_rd_en_o),
        .pal_rd_addr_o (pal_rd_addr_o),
        .pal_rd_data_i (pal_rd_data_i)
    );

    // Palette RAM: registered read; garbage on idle cycles so stale data shows up.
    always @(posedge clk) begin
        if (pal_rd_en_o) pal_rd_data_i <= mem[pal_rd_addr_o];
        else             pal_rd_data_i <= 16'($urandom);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] eff_idx(input logic [7:0] idx);
`ifdef PALETTE_READER_OFFSET_EN
        if (idx == 8'd0) return idx;
        return {4'((int'(idx[7:4]) + int'(pal_offset_i)) % 16), idx[3:0]};
`else
        return idx;
`endif
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic acc;
        logic [7:0] e;
        if (rst_i) begin
            exp_q.delete();
        end else begin
            if (rgb_valid_o && rgb_ready_i) begin
                if (exp_q.size() == 0) chk("spurious_output", 32'(rgb_o), 32'hFFFF_FFFF);
                else chk("rgb_data", 32'(rgb_o), 32'(exp_q.pop_front()));
            end
            acc = pix_valid_i & pix_ready_o;
            chk("rd_en", 32'(pal_rd_en_o), 32'(acc & ~pix_blank_i));
            if (acc) begin
                acc_cnt++;
                e = eff_idx(pix_idx_i);
                if (!pix_blank_i) chk("rd_addr", 32'(pal_rd_addr_o), 32'(e));
                exp_q.push_back(pix_blank_i ? 12'h000 : mem[e][11:0]);
            end
        end
    end

    task automatic send(input logic [7:0] idx, input logic blank);
        bit ok = 0;
        pix_valid_i = 1'b1;
        pix_idx_i   = idx;
        pix_blank_i = blank;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pix_ready_o) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        pix_valid_i = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        rgb_ready_i = 1'b1;
        pix_valid_i = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rgb_valid_o) begin ok = 1; break; end
        end
        chk("drain_done", 32'(ok), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int a0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[5] = 16'hF0A3;
        mem[1] = 16'h0FFF;
        rst_i = 1'b1; pix_valid_i = 1'b0; pix_idx_i = '0; pix_blank_i = 1'b0;
        rgb_ready_i = 1'b1;
`ifdef PALETTE_READER_OFFSET_EN
        pal_offset_i = 4'h0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(rgb_valid_o), 0);
        chk("rst_rgb", 32'(rgb_o), 0);
        chk("rst_ready", 32'(pix_ready_o), 0);
        chk("rst_rd_en", 32'(pal_rd_en_o), 0);
        @(posedge clk); #1;
        rst_i = 1'b0;

        // Single read: address and enable in the accept cycle, data one stage later.
        pix_valid_i = 1'b1; pix_idx_i = 8'd5; pix_blank_i = 1'b0;
        @(negedge clk);
        chk("lat_rd_en", 32'(pal_rd_en_o), 1);
        chk("lat_rd_addr", 32'(pal_rd_addr_o), 5);
        @(posedge clk); #1;
        pix_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("lat_valid", 32'(rgb_valid_o), 1);
        chk("lat_rgb", 32'(rgb_o), 32'h0A3);
        drain();

        // Back-to-back at full rate.
        for (int i = 0; i < 16; i++) begin
            pix_valid_i = 1'b1; pix_idx_i = 8'(i); pix_blank_i = 1'b0;
            @(negedge clk);
            chk("b2b_ready", 32'(pix_ready_o), 1);
            if (i >= 2) chk("b2b_valid", 32'(rgb_valid_o), 1);
            @(posedge clk); #1;
        end
        pix_valid_i = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("b2b_valid_tail", 32'(rgb_valid_o), 1);
        end
        drain();

        // Downstream stall: exactly DEPTH pixels accepted, then backpressure.
        rgb_ready_i = 1'b0;
        a0 = acc_cnt;
        for (int i = 0; i < 10; i++) begin
            pix_valid_i = 1'b1; pix_idx_i = 8'($urandom); pix_blank_i = 1'b0;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("stall_accepted", 32'(acc_cnt - a0), 32'(DEPTH));
        chk("stall_ready", 32'(pix_ready_o), 0);
        chk("stall_valid", 32'(rgb_valid_o), 1);
        @(posedge clk); #1;
        drain();
        chk("stall_no_dup", 32'(exp_q.size()), 0);

        // Blank pixels interleaved with idx 1.
        for (int i = 0; i < 8; i++) send(8'd1, 1'(i % 2 == 0));
        drain();

        // Reset with two pixels buffered and one in flight.
        rgb_ready_i = 1'b0;
        send(8'd5, 1'b0);
        send(8'd1, 1'b0);
        send(8'd7, 1'b0);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(rgb_valid_o), 0);
        chk("midrst_ready", 32'(pix_ready_o), 1);
        @(negedge clk);
        chk("midrst_no_push", 32'(rgb_valid_o), 0);
        @(posedge clk); #1;
        rgb_ready_i = 1'b1;
        send(8'd5, 1'b0);
        drain();

`ifdef PALETTE_READER_OFFSET_EN
        pal_offset_i = 4'h3;
        pix_valid_i = 1'b1; pix_blank_i = 1'b0; pix_idx_i = 8'h12;
        @(negedge clk); chk("ofs_12", 32'(pal_rd_addr_o), 32'h42);
        @(posedge clk); #1; pix_idx_i = 8'h00;
        @(negedge clk); chk("ofs_00", 32'(pal_rd_addr_o), 32'h00);
        @(posedge clk); #1; pix_idx_i = 8'hF1;
        @(negedge clk); chk("ofs_F1", 32'(pal_rd_addr_o), 32'h21);
        @(posedge clk); #1;
        drain();
`endif

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            pix_valid_i = ($urandom_range(0, 9) < 7);
            pix_idx_i   = 8'($urandom);
            pix_blank_i = ($urandom_range(0, 6) == 0);
            rgb_ready_i = ($urandom_range(0, 3) != 0);
`ifdef PALETTE_READER_OFFSET_EN
            pal_offset_i = 4'($urandom);
`endif
            @(posedge clk); #1;
        end
        drain();
        @(negedge clk);
        chk("final_idle", 32'(rgb_valid_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
